os_pe_sequencer: RTL and testbench
==================================

Name: os_pe_sequencer

Overview:
- Control/data sequencer for one output-stationary PE chain of CHAIN_LEN PEs linked through their forward ports.
- Upstream side: accepts a tile command and a valid/ready stream of (weight, input) operand pairs. Drives the chain's ready/rw/stream control and operand buses.
- Downstream side: captures the drained partial sums from the chain tail output into a result FIFO with valid/ready handshake.

Parameters:
WEIGHT_WIDTH, 8, operand weight width
INPUT_WIDTH, 8, operand input width
FWD_WIDTH, 16, PE forward/result width
CHAIN_LEN, 4, PEs in the chain = results drained per tile (>=1)
K_WIDTH, 8, width of MAC count field
FIFO_DEPTH, 8, result FIFO entries (power of 2, >= CHAIN_LEN)

Ports:
w_clk  in  1  clock
w_rst_n  in  1  async active-low reset
i_start  in  1  tile start request; accepted only in IDLE with enough FIFO space
i_k  in  K_WIDTH  MAC pairs per tile, sampled on start accept; 0 legal
o_busy  out  1  high from start accept until DONE
o_done  out  1  one-cycle pulse in DONE state
i_op_valid  in  1  operand pair valid
o_op_ready  out  1  operand pair accepted this cycle (MAC state only)
i_op_weight  in  WEIGHT_WIDTH  operand weight
i_op_input  in  INPUT_WIDTH  operand input
o_pe_ready  out  1  to chain w_ready (0 = load/clear)
o_pe_rw  out  1  to chain w_rw
o_pe_stream  out  1  to chain w_stream
o_pe_weight  out  WEIGHT_WIDTH  to chain w_weight
o_pe_input  out  INPUT_WIDTH  to chain w_input
i_pe_out  in  FWD_WIDTH  from chain-tail w_out
o_res_valid  out  1  FIFO non-empty
i_res_ready  in  1  downstream accepts head
o_res_data  out  FWD_WIDTH  FIFO head
o_res_count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, w_rst_n=0): state IDLE; FIFO emptied; k counter and drain counter 0; capture pipeline cleared. Outputs: o_busy=0, o_done=0, o_op_ready=0, o_pe_ready=1, o_pe_rw=0, o_pe_stream=0, o_pe_weight=0, o_pe_input=0, o_res_valid=0, o_res_data=0, o_res_count=0. Reset mid-tile abandons the tile with no partial result.
- All o_pe_* outputs are registered; the chain sees them one cycle after the state decision.
- Start accept: IDLE and i_start and (FIFO_DEPTH - o_res_count) >= CHAIN_LEN. Otherwise i_start is ignored (no queuing). Latch i_k and go to LOAD.
- LOAD (1 cycle): pe_ready=0, weight=input=0. Clears every PE scratch. Next state is MAC, or DRAIN if k=0.
- MAC: o_op_ready=1. On i_op_valid: pe_ready=1, rw=1, stream=0, operands passed through, k_cnt++. Without valid (bubble): pe_ready=1, rw=0, stream=0, operands 0, so no accumulation. When the K-th pair is accepted, go to DRAIN next cycle.
- DRAIN (exactly CHAIN_LEN cycles): pe_ready=1, rw=1, stream=1, operands forced 0. The gated product is 0, so scratch is held while values shift down the forward chain. Each drain cycle schedules a capture.
- Capture: i_pe_out is sampled 2 cycles after the corresponding DRAIN state cycle (1 cycle for the registered control, 1 for the PE output register), using a 2-deep shift of capture-enable bits. The FIFO is written with exactly CHAIN_LEN words per tile, in chain-tail-first order.
- FLUSH: wait until the capture pipe is empty, then DONE.
- DONE (1 cycle): o_done=1, then IDLE. o_busy=1 in LOAD/MAC/DRAIN/FLUSH/DONE.
- FIFO: synchronous, FIFO_DEPTH entries, pointer width clog2(FIFO_DEPTH)+1 with wrap bit.
  - o_res_data shows the head (0 when empty).
  - Pop when o_res_valid and i_res_ready.
  - A push and a pop in the same cycle are both performed; count is unchanged.
  - Overflow cannot occur because of the admission rule. A push while full is a design error, flagged by an assertion.
- Arithmetic: none beyond counters. k_cnt compare is K_WIDTH wide; drain counter is clog2(CHAIN_LEN)+1 wide.
- Start during busy: ignored. i_op_valid outside MAC: ignored, o_op_ready=0.

Decomposition:
- Shared package os_pkg holds the state enum (IDLE, LOAD, MAC, DRAIN, FLUSH, DONE) and constants CAPTURE_LAT=2 and the PE_MODE encodings (LOAD, MAC, HOLD, STREAM).
- One sub-module: os_result_fifo (parameterised sync FIFO with count output).

Test Plan:
- k=3, CHAIN_LEN=1, pairs (2,3),(4,5),(0,7), single real PE model -> one result 26; o_done pulses once; o_res_count returns to 0 after pop.
- k=2 with a bubble between pairs (valid low 3 cycles), pairs (1,1),(10,10) -> result 101; pe_rw=0 during every bubble cycle.
- k=0 -> LOAD then DRAIN directly; CHAIN_LEN results of 0 are pushed.
- CHAIN_LEN=4, FIFO_DEPTH=8, i_res_ready=0, two tiles, then third start -> third start ignored (count=8); after 4 pops, start is accepted.
- Assert w_rst_n=0 mid-MAC after 2 of 5 pairs -> all outputs at reset values asynchronously; next tile result is correct with no stale data.
- i_res_ready=1 during capture of a full drain burst -> simultaneous push/pop keeps count steady; data order is preserved.

Source files
------------

// File: rtl/os_pkg.sv
// Shared types for the output-stationary PE chain sequencer: FSM states,
// PE control modes and the capture latency between a drain decision and its sample.
package os_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MAC,
        ST_DRAIN,
        ST_FLUSH,
        ST_DONE
    } seq_state_e;

    typedef enum logic [1:0] {
        PE_LOAD,
        PE_MAC,
        PE_HOLD,
        PE_STREAM
    } pe_mode_e;

    typedef struct packed {
        logic ready;
        logic rw;
        logic stream;
    } pe_ctrl_t;

    // One cycle for the registered chain controls, one for the PE output register.
    localparam int CAPTURE_LAT = 2;

    function automatic pe_ctrl_t pe_ctrl(input pe_mode_e mode);
        pe_ctrl_t c;
        c = '{ready: 1'b1, rw: 1'b0, stream: 1'b0};
        case (mode)
            PE_LOAD:   c = '{ready: 1'b0, rw: 1'b0, stream: 1'b0};
            PE_MAC:    c = '{ready: 1'b1, rw: 1'b1, stream: 1'b0};
            PE_HOLD:   c = '{ready: 1'b1, rw: 1'b0, stream: 1'b0};
            PE_STREAM: c = '{ready: 1'b1, rw: 1'b1, stream: 1'b1};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/os_result_fifo.sv
// Synchronous result FIFO with wrap-bit pointers, occupancy output and a
// zero-masked head word when empty.
module os_result_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
) (
    input  logic                       w_clk,
    input  logic                       w_rst_n,
    input  logic                       push_i,
    input  logic [DATA_WIDTH-1:0]      push_data_i,
    input  logic                       pop_i,
    output logic                       valid_o,
    output logic [DATA_WIDTH-1:0]      head_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] mem_q [2**AW];
    logic [AW:0]           wr_ptr_q, rd_ptr_q;
    logic [AW:0]           used;
    logic                  empty, full, pop_fire;

    assign used     = wr_ptr_q - rd_ptr_q;
    assign empty    = (used == '0);
    assign full     = (used == (AW+1)'(DEPTH));
    assign pop_fire = pop_i && !empty;

    // NOTE: storage has no reset; every read path is qualified by the pointers,
    // so clearing the pointers is enough and the array maps onto plain RAM.
    always_ff @(posedge w_clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    // NOTE: state updates use <= so every register samples pre-edge values
    // regardless of process ordering.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_fire) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign valid_o = !empty;
    assign head_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign count_o = CW'(used);

    // Admission control upstream guarantees room for a whole drain burst.
    a_no_overflow: assert property (@(posedge w_clk) disable iff (!w_rst_n) !(push_i && full));

endmodule

// File: rtl/os_pe_sequencer.sv
// Tile sequencer for an output-stationary PE chain: clears, feeds MAC operands,
// drains partial sums tail-first and captures them into the result FIFO.
module os_pe_sequencer
    import os_pkg::*;
#(
    parameter int WEIGHT_WIDTH = 8,
    parameter int INPUT_WIDTH  = 8,
    parameter int FWD_WIDTH    = 16,
    parameter int CHAIN_LEN    = 4,
    parameter int K_WIDTH      = 8,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          w_clk,
    input  logic                          w_rst_n,
    input  logic                          i_start,
    input  logic [K_WIDTH-1:0]            i_k,
    output logic                          o_busy,
    output logic                          o_done,
    input  logic                          i_op_valid,
    output logic                          o_op_ready,
    input  logic [WEIGHT_WIDTH-1:0]       i_op_weight,
    input  logic [INPUT_WIDTH-1:0]        i_op_input,
    output logic                          o_pe_ready,
    output logic                          o_pe_rw,
    output logic                          o_pe_stream,
    output logic [WEIGHT_WIDTH-1:0]       o_pe_weight,
    output logic [INPUT_WIDTH-1:0]        o_pe_input,
    input  logic [FWD_WIDTH-1:0]          i_pe_out,
    output logic                          o_res_valid,
    input  logic                          i_res_ready,
    output logic [FWD_WIDTH-1:0]          o_res_data,
    output logic [$clog2(FIFO_DEPTH):0]   o_res_count
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = $clog2(CHAIN_LEN) + 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CHAIN_C    = CW'(CHAIN_LEN);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(CHAIN_LEN - 1);

    seq_state_e               state_q, state_d;
    logic [K_WIDTH-1:0]       k_q, k_d, k_cnt_q, k_cnt_d;
    logic [DW-1:0]            drain_cnt_q, drain_cnt_d;
    logic [CAPTURE_LAT-1:0]   cap_q;
    pe_ctrl_t                 ctrl_q, ctrl_d;
    logic [WEIGHT_WIDTH-1:0]  weight_q, weight_d;
    logic [INPUT_WIDTH-1:0]   input_q, input_d;
    logic [CW-1:0]            free_slots;
    logic                     start_ok, op_fire;

    // A tile is only admitted when its whole drain burst is guaranteed to fit.
    assign free_slots = DEPTH_C - o_res_count;
    assign start_ok   = (state_q == ST_IDLE) && i_start && (free_slots >= CHAIN_C);
    assign op_fire    = (state_q == ST_MAC) && i_op_valid;

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        k_cnt_d     = k_cnt_q;
        drain_cnt_d = drain_cnt_q;
        ctrl_d      = pe_ctrl(PE_HOLD);
        weight_d    = '0;
        input_d     = '0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    k_d     = i_k;
                    k_cnt_d = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ctrl_d      = pe_ctrl(PE_LOAD);
                drain_cnt_d = '0;
                state_d     = (k_q == '0) ? ST_DRAIN : ST_MAC;
            end
            ST_MAC: begin
                if (op_fire) begin
                    ctrl_d   = pe_ctrl(PE_MAC);
                    weight_d = i_op_weight;
                    input_d  = i_op_input;
                    k_cnt_d  = k_cnt_q + 1'b1;
                    if (k_cnt_d == k_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Zero operands gate the product, so scratch holds while sums shift out.
                ctrl_d      = pe_ctrl(PE_STREAM);
                drain_cnt_d = drain_cnt_q + 1'b1;
                if (drain_cnt_q == DRAIN_LAST) begin
                    drain_cnt_d = '0;
                    state_d     = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (cap_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            k_cnt_q     <= '0;
            drain_cnt_q <= '0;
            cap_q       <= '0;
            ctrl_q      <= pe_ctrl(PE_HOLD);
            weight_q    <= '0;
            input_q     <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            k_cnt_q     <= k_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            cap_q       <= {cap_q[CAPTURE_LAT-2:0], state_q == ST_DRAIN};
            ctrl_q      <= ctrl_d;
            weight_q    <= weight_d;
            input_q     <= input_d;
        end
    end

    assign o_busy      = (state_q != ST_IDLE);
    assign o_done      = (state_q == ST_DONE);
    assign o_op_ready  = (state_q == ST_MAC);
    assign o_pe_ready  = ctrl_q.ready;
    assign o_pe_rw     = ctrl_q.rw;
    assign o_pe_stream = ctrl_q.stream;
    assign o_pe_weight = weight_q;
    assign o_pe_input  = input_q;

    os_result_fifo #(
        .DATA_WIDTH (FWD_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .w_clk       (w_clk),
        .w_rst_n     (w_rst_n),
        .push_i      (cap_q[CAPTURE_LAT-1]),
        .push_data_i (i_pe_out),
        .pop_i       (i_res_ready),
        .valid_o     (o_res_valid),
        .head_o      (o_res_data),
        .count_o     (o_res_count)
    );

endmodule

// File: tb/tb_os_pe_sequencer.sv
// Directed bench: a one-PE instance and a four-PE instance, each fed by a
// behavioural PE chain, with queued expected results checked as they pop.
module tb_os_pe_sequencer;

    logic w_clk   = 1'b0;
    logic w_rst_n = 1'b0;
    always #5 w_clk = ~w_clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: CHAIN_LEN=1, FIFO_DEPTH=2
    logic        start_a = 0, opv_a = 0, rr_a = 0;
    logic [7:0]  k_a = 0, opw_a = 0, opi_a = 0;
    logic        busy_a, done_a, opr_a, per_a, perw_a, pes_a, rv_a;
    logic [7:0]  pew_a, pei_a;
    logic [15:0] peo_a, rd_a;
    logic [1:0]  rc_a;

    // Instance B: CHAIN_LEN=4, FIFO_DEPTH=8
    logic        start_b = 0, opv_b = 0, rr_b = 0;
    logic [7:0]  k_b = 0, opw_b = 0, opi_b = 0;
    logic        busy_b, done_b, opr_b, per_b, perw_b, pes_b, rv_b;
    logic [7:0]  pew_b, pei_b;
    logic [15:0] peo_b, rd_b;
    logic [3:0]  rc_b;

    logic [15:0] exp_a[$];
    logic [15:0] exp_b[$];
    logic [15:0] mon_word;

    os_pe_sequencer #(.CHAIN_LEN(1), .FIFO_DEPTH(2)) dut_a (
        .w_clk(w_clk), .w_rst_n(w_rst_n), .i_start(start_a), .i_k(k_a),
        .o_busy(busy_a), .o_done(done_a), .i_op_valid(opv_a), .o_op_ready(opr_a),
        .i_op_weight(opw_a), .i_op_input(opi_a), .o_pe_ready(per_a), .o_pe_rw(perw_a),
        .o_pe_stream(pes_a), .o_pe_weight(pew_a), .o_pe_input(pei_a), .i_pe_out(peo_a),
        .o_res_valid(rv_a), .i_res_ready(rr_a), .o_res_data(rd_a), .o_res_count(rc_a)
    );

    os_pe_sequencer #(.CHAIN_LEN(4), .FIFO_DEPTH(8)) dut_b (
        .w_clk(w_clk), .w_rst_n(w_rst_n), .i_start(start_b), .i_k(k_b),
        .o_busy(busy_b), .o_done(done_b), .i_op_valid(opv_b), .o_op_ready(opr_b),
        .i_op_weight(opw_b), .i_op_input(opi_b), .o_pe_ready(per_b), .o_pe_rw(perw_b),
        .o_pe_stream(pes_b), .o_pe_weight(pew_b), .o_pe_input(pei_b), .i_pe_out(peo_b),
        .o_res_valid(rv_b), .i_res_ready(rr_b), .o_res_data(rd_b), .o_res_count(rc_b)
    );

    // PE chain models: PE j applies gain (j+1) so drained words are distinguishable.
    // Stream mode shifts scratch toward the tail; the tail output register shows it.
    logic [15:0] acc_a;
    always @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            acc_a <= '0;
            peo_a <= '0;
        end else if (!per_a) begin
            acc_a <= '0;
        end else if (perw_a && !pes_a) begin
            acc_a <= acc_a + 16'(pew_a) * 16'(pei_a);
        end else if (perw_a && pes_a) begin
            peo_a <= acc_a;
            acc_a <= '0;
        end
    end

    logic [15:0] acc_b [4];
    always @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int j = 0; j < 4; j++) acc_b[j] <= '0;
            peo_b <= '0;
        end else if (!per_b) begin
            for (int j = 0; j < 4; j++) acc_b[j] <= '0;
        end else if (perw_b && !pes_b) begin
            for (int j = 0; j < 4; j++)
                acc_b[j] <= acc_b[j] + 16'(pew_b) * 16'(pei_b) * 16'(j + 1);
        end else if (perw_b && pes_b) begin
            peo_b    <= acc_b[3];
            acc_b[0] <= '0;
            for (int j = 1; j < 4; j++) acc_b[j] <= acc_b[j-1];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted pop is compared with the oldest expected word.
    always @(negedge w_clk) begin
        if (w_rst_n && rv_a && rr_a) begin
            check("a_pop_expected", 32'(exp_a.size() != 0), 32'd1);
            if (exp_a.size() != 0) begin
                mon_word = exp_a.pop_front();
                check("a_pop_data", 32'(rd_a), 32'(mon_word));
            end
        end
        if (w_rst_n && rv_b && rr_b) begin
            check("b_pop_expected", 32'(exp_b.size() != 0), 32'd1);
            if (exp_b.size() != 0) begin
                mon_word = exp_b.pop_front();
                check("b_pop_data", 32'(rd_b), 32'(mon_word));
            end
        end
    end

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    task automatic start_tile(input bit b, input logic [7:0] k);
        if (b) begin start_b = 1'b1; k_b = k; end
        else   begin start_a = 1'b1; k_a = k; end
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic send_pair(input bit b, input logic [7:0] w, input logic [7:0] x);
        bit taken;
        taken = 1'b0;
        if (b) begin opv_b = 1'b1; opw_b = w; opi_b = x; end
        else   begin opv_a = 1'b1; opw_a = w; opi_a = x; end
        for (int n = 0; n < 40 && !taken; n++) begin
            @(negedge w_clk);
            taken = b ? opr_b : opr_a;
            tick();
        end
        opv_a = 1'b0; opw_a = '0; opi_a = '0;
        opv_b = 1'b0; opw_b = '0; opi_b = '0;
        check("pair_accepted", 32'(taken), 32'd1);
    endtask

    task automatic wait_done(input bit b, output int max_cnt);
        int pulses;
        pulses  = 0;
        max_cnt = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge w_clk);
            if (b ? done_b : done_a) pulses++;
            if (int'(b ? rc_b : 4'(rc_a)) > max_cnt) max_cnt = int'(b ? rc_b : 4'(rc_a));
            if (!(b ? busy_b : busy_a)) break;
        end
        check("busy_released", 32'(b ? busy_b : busy_a), 32'd0);
        check("done_pulses", 32'(pulses), 32'd1);
    endtask

    task automatic check_reset_b();
        check("rst_busy",   32'(busy_b), 32'd0);
        check("rst_done",   32'(done_b), 32'd0);
        check("rst_op_rdy", 32'(opr_b),  32'd0);
        check("rst_pe_rdy", 32'(per_b),  32'd1);
        check("rst_pe_rw",  32'(perw_b), 32'd0);
        check("rst_pe_str", 32'(pes_b),  32'd0);
        check("rst_pe_w",   32'(pew_b),  32'd0);
        check("rst_pe_in",  32'(pei_b),  32'd0);
        check("rst_res_v",  32'(rv_b),   32'd0);
        check("rst_res_d",  32'(rd_b),   32'd0);
        check("rst_res_c",  32'(rc_b),   32'd0);
    endtask

    initial begin
        int max_cnt;

        // Reset state
        #12;
        check_reset_b();
        check("rst_a_count", 32'(rc_a), 32'd0);
        @(negedge w_clk);
        w_rst_n = 1'b1;
        tick();

        // Operand valid outside MAC is ignored
        opv_a = 1'b1;
        #1;
        check("a_idle_op_ready", 32'(opr_a), 32'd0);
        opv_a = 1'b0;

        // Single PE, k=3: 2*3 + 4*5 + 0*7 = 26
        exp_a.push_back(16'd26);
        start_tile(1'b0, 8'd3);
        check("a_busy_after_start", 32'(busy_a), 32'd1);
        send_pair(1'b0, 8'd2, 8'd3);
        send_pair(1'b0, 8'd4, 8'd5);
        send_pair(1'b0, 8'd0, 8'd7);
        wait_done(1'b0, max_cnt);
        tick();
        check("a_count_one", 32'(rc_a), 32'd1);
        check("a_valid", 32'(rv_a), 32'd1);
        rr_a = 1'b1;
        tick();
        rr_a = 1'b0;
        check("a_count_zero", 32'(rc_a), 32'd0);

        // k=2 with a 3-cycle bubble: sum 1*1 + 10*10 = 101, drained as 404,303,202,101
        rr_b = 1'b1;
        exp_b.push_back(16'd404); exp_b.push_back(16'd303);
        exp_b.push_back(16'd202); exp_b.push_back(16'd101);
        start_tile(1'b1, 8'd2);
        send_pair(1'b1, 8'd1, 8'd1);
        for (int n = 0; n < 3; n++) begin
            tick();
            check("bubble_rw", 32'(perw_b), 32'd0);
            check("bubble_op_ready", 32'(opr_b), 32'd1);
        end
        send_pair(1'b1, 8'd10, 8'd10);
        wait_done(1'b1, max_cnt);

        // k=0: LOAD then straight to DRAIN, four zero results; start while busy is ignored
        tick();
        repeat (4) exp_b.push_back(16'd0);
        start_tile(1'b1, 8'd0);
        tick();
        check("k0_load_ready", 32'(per_b), 32'd0);
        tick();
        check("k0_drain_stream", 32'(pes_b), 32'd1);
        check("k0_no_mac", 32'(opr_b), 32'd0);
        start_tile(1'b1, 8'd0);
        wait_done(1'b1, max_cnt);
        tick();
        check("k0_busy_start_ignored", 32'(busy_b), 32'd0);
        check("k0_fifo_drained", 32'(rc_b), 32'd0);

        // Admission control: two tiles fill the FIFO, third start is ignored
        rr_b = 1'b0;
        exp_b.push_back(16'd8);  exp_b.push_back(16'd6);
        exp_b.push_back(16'd4);  exp_b.push_back(16'd2);
        start_tile(1'b1, 8'd1);
        send_pair(1'b1, 8'd1, 8'd2);
        wait_done(1'b1, max_cnt);
        tick();
        exp_b.push_back(16'd12); exp_b.push_back(16'd9);
        exp_b.push_back(16'd6);  exp_b.push_back(16'd3);
        start_tile(1'b1, 8'd1);
        send_pair(1'b1, 8'd3, 8'd1);
        wait_done(1'b1, max_cnt);
        tick();
        check("full_count", 32'(rc_b), 32'd8);
        start_tile(1'b1, 8'd1);
        check("full_start_ignored", 32'(busy_b), 32'd0);
        check("full_count_kept", 32'(rc_b), 32'd8);
        rr_b = 1'b1;
        repeat (4) tick();
        rr_b = 1'b0;
        check("after_pops_count", 32'(rc_b), 32'd4);
        repeat (4) exp_b.push_back(16'd0);
        start_tile(1'b1, 8'd0);
        check("space_start_accepted", 32'(busy_b), 32'd1);
        wait_done(1'b1, max_cnt);
        tick();
        check("refill_count", 32'(rc_b), 32'd8);
        rr_b = 1'b1;
        for (int n = 0; n < 20 && rc_b != 0; n++) tick();
        rr_b = 1'b0;
        check("emptied_count", 32'(rc_b), 32'd0);
        check("queue_b_empty", 32'(exp_b.size()), 32'd0);

        // Reset mid-MAC after 2 of 5 pairs abandons the tile
        start_tile(1'b1, 8'd5);
        send_pair(1'b1, 8'd3, 8'd3);
        send_pair(1'b1, 8'd4, 8'd4);
        #2;
        w_rst_n = 1'b0;
        #1;
        check_reset_b();
        @(negedge w_clk);
        w_rst_n = 1'b1;
        tick();
        exp_b.push_back(16'd100); exp_b.push_back(16'd75);
        exp_b.push_back(16'd50);  exp_b.push_back(16'd25);
        rr_b = 1'b1;
        start_tile(1'b1, 8'd1);
        send_pair(1'b1, 8'd5, 8'd5);
        wait_done(1'b1, max_cnt);

        // Push and pop together during a drain burst: count never exceeds 1
        tick();
        exp_b.push_back(16'd28); exp_b.push_back(16'd21);
        exp_b.push_back(16'd14); exp_b.push_back(16'd7);
        start_tile(1'b1, 8'd2);
        send_pair(1'b1, 8'd2, 8'd2);
        send_pair(1'b1, 8'd1, 8'd3);
        wait_done(1'b1, max_cnt);
        check("burst_max_count", 32'(max_cnt), 32'd1);
        tick();
        tick();
        check("burst_final_count", 32'(rc_b), 32'd0);
        check("queue_a_done", 32'(exp_a.size()), 32'd0);
        check("queue_b_done", 32'(exp_b.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
